dmem_arbiter: RTL

- Shares the single-port data memory between two requesters.
- Port 0 is the instruction-fetch read port (read-only). Port 1 is the memory-stage load/store port.
- Sequences each access through a fixed read latency and returns read data to the owning requester.
- Port 1 has priority, with a starvation bound that guarantees fetch forward progress. Sits between the pipeline stages and the dataMemory instance.

---
 rtl/dmem_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory.
// Port 0 is the instruction-fetch read port, port 1 the load/store port.
// The load/store port has priority, but fetch wins once it has lost
// MAX_WAIT slots in a row. Read data is passed straight through from the
// memory to whichever port owns the read in flight.
module dmem_arbiter #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 32,
    parameter int RD_LAT   = 1,   // 1..7
    parameter int MAX_WAIT = 3    // 1..15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_gnt,
    output logic              mem_rvalid,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

    typedef enum logic {S_IDLE, S_WAIT} state_e;
    typedef enum logic {OWN_IF, OWN_MEM} owner_e;

    localparam logic [2:0] LAT_INIT   = 3'(RD_LAT - 1);
    localparam logic [3:0] STARVE_MAX = 4'(MAX_WAIT);

    state_e      state_q, state_d;
    owner_e      owner_q, owner_d;
    logic [2:0]  lat_cnt_q, lat_cnt_d;
    logic [3:0]  starve_cnt_q, starve_cnt_d;

    logic slot;
    logic resp;
    logic fetch_win;
    logic mem_win;

    // Arbitration, grant outputs, response routing and next-state logic.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        if_gnt       = 1'b0;
        mem_gnt      = 1'b0;
        if_rvalid    = 1'b0;
        mem_rvalid   = 1'b0;
        if_rdata     = '0;
        mem_rdata    = '0;
        ram_en       = 1'b0;
        ram_we       = 1'b0;
        ram_addr     = '0;
        ram_wdata    = '0;
        state_d      = state_q;
        owner_d      = owner_q;
        lat_cnt_d    = lat_cnt_q;
        starve_cnt_d = starve_cnt_q;

        busy = (state_q == S_WAIT);
        resp = (state_q == S_WAIT) && (lat_cnt_q == 3'd0);
        // Grants are held off while reset is asserted so every output reads 0.
        slot = rst_n && ((state_q == S_IDLE) || (lat_cnt_q == 3'd0));

        fetch_win = slot && if_req && ((starve_cnt_q == STARVE_MAX) || !mem_req);
        mem_win   = slot && mem_req && !fetch_win;

        // Latency countdown; a finishing read returns to IDLE unless a new read is granted below.
        if (state_q == S_WAIT) begin
            if (lat_cnt_q != 3'd0) begin
                lat_cnt_d = lat_cnt_q - 3'd1;
            end else begin
                state_d = S_IDLE;
            end
        end

        if (resp) begin
            if (owner_q == OWN_IF) begin
                if_rvalid = 1'b1;
                if_rdata  = ram_rdata;
            end else begin
                mem_rvalid = 1'b1;
                mem_rdata  = ram_rdata;
            end
        end

        if (mem_win) begin
            mem_gnt   = 1'b1;
            ram_en    = 1'b1;
            ram_we    = mem_we;
            ram_addr  = mem_addr;
            ram_wdata = mem_wdata;
            // A store completes in its grant cycle and leaves the state as computed above.
            if (!mem_we) begin
                state_d   = S_WAIT;
                owner_d   = OWN_MEM;
                lat_cnt_d = LAT_INIT;
            end
            if (!if_req) begin
                starve_cnt_d = '0;
            end else if (starve_cnt_q != STARVE_MAX) begin
                starve_cnt_d = starve_cnt_q + 4'd1;
            end
        end else if (fetch_win) begin
            if_gnt       = 1'b1;
            ram_en       = 1'b1;
            ram_addr     = if_addr;
            state_d      = S_WAIT;
            owner_d      = OWN_IF;
            lat_cnt_d    = LAT_INIT;
            starve_cnt_d = '0;
        end else if (slot) begin
            // No grant in a slot means fetch is not requesting.
            starve_cnt_d = '0;
        end
    end

    // State registers; reset drops any read in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            owner_q      <= OWN_IF;
            lat_cnt_q    <= '0;
            starve_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so all registers update from pre-edge values.
            state_q      <= state_d;
            owner_q      <= owner_d;
            lat_cnt_q    <= lat_cnt_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule
